// File: rtl/msx_audio_pkg.sv
// Shared types and constants for the MSX audio post-processing stage.
//   AUDIO_W            : external sample width
//   audio_post_state_t : sequencing states of msx_audio_post
//   VOL_UNITY          : volume code giving unity gain (1/8 steps)
package msx_audio_pkg;

   localparam int unsigned AUDIO_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      CAPT,
      DCB,
      LPF,
      VOL,
      SAT
   } audio_post_state_t;

   localparam logic [3:0] VOL_UNITY = 4'd8;

endpackage

// File: rtl/sat_clamp.sv
// Combinational saturating narrow: signed IN_W-bit value -> signed AUDIO_W-bit.
//   value     : signed input, IN_W bits (IN_W > AUDIO_W)
//   clamped_c : value clamped to [-32768, 32767]
module sat_clamp
   import msx_audio_pkg::*;
#(
   parameter int unsigned IN_W = 24
) (
   input  logic signed [IN_W-1:0]    value,
   output logic signed [AUDIO_W-1:0] clamped_c
);

   localparam logic signed [IN_W-1:0] MAX_V = IN_W'(32'sd32767);
   localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-32'sd32768);

   always_comb begin
      clamped_c = value[AUDIO_W-1:0];
      if (value > MAX_V) begin
         clamped_c = 16'sh7fff;
      end else if (value < MIN_V) begin
         clamped_c = 16'sh8000;
      end
   end

endmodule

// File: rtl/msx_audio_post.sv
// Audio post-processing: DC blocker -> one-pole low-pass -> 4-bit volume -> saturate.
//   clk, reset : system clock, async active-high reset
//   ce_sample  : one-clk sample strobe; audio_in captured on it
//   audio_in   : signed 16-bit input sample
//   dcb_en     : enable DC blocker
//   lpf_en     : enable low-pass; lpf_shift is its coefficient k (0 = bypass)
//   volume     : gain in 1/8 steps (8 = unity)
//   audio_out  : processed sample, held between updates
//   out_valid  : one-clk pulse, high during the SAT cycle
//   overrun    : sticky, set when ce_sample arrives while busy
module msx_audio_post
   import msx_audio_pkg::*;
#(
   parameter int unsigned ACC_W     = 20,
   parameter int unsigned DCB_SHIFT = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ce_sample,
   input  logic signed [AUDIO_W-1:0] audio_in,
   input  logic                      dcb_en,
   input  logic                      lpf_en,
   input  logic [2:0]                lpf_shift,
   input  logic [3:0]                volume,
   output logic signed [AUDIO_W-1:0] audio_out,
   output logic                      out_valid,
   output logic                      overrun
);

   localparam int unsigned PROD_W = ACC_W + 4;

   audio_post_state_t state;

   logic signed [ACC_W-1:0] x, x_prev, y_dcb, l_acc, d, f;

   logic signed [ACC_W-1:0]   dcb_y_c;
   logic signed [ACC_W-1:0]   lpf_diff_c;
   logic signed [ACC_W-1:0]   lpf_l_c;
   logic signed [PROD_W-1:0]  f_ext_c;
   logic signed [PROD_W-1:0]  vol_ext_c;
   logic signed [PROD_W-1:0]  prod_c;
   logic signed [PROD_W-1:0]  v_c;
   logic signed [AUDIO_W-1:0] sat_c;

   // Filter arithmetic; everything wraps at ACC_W bits.
   assign dcb_y_c    = x - x_prev + y_dcb - (y_dcb >>> DCB_SHIFT);
   assign lpf_diff_c = d - l_acc;
   assign lpf_l_c    = l_acc + (lpf_diff_c >>> lpf_shift);

   // Volume scale with 4 guard bits so 15 * full-scale cannot wrap.
   assign f_ext_c   = PROD_W'(f);
   assign vol_ext_c = PROD_W'(volume);
   assign prod_c    = f_ext_c * vol_ext_c;
   assign v_c       = prod_c >>> 3;

   sat_clamp #(.IN_W(PROD_W)) u_sat (
      .value     (v_c),
      .clamped_c (sat_c)
   );

   // Sequencer. audio_in is captured on the strobe edge itself so it only needs
   // to be valid alongside ce_sample. The output registers load on the VOL->SAT
   // edge, so out_valid is high during SAT, 5 clk after the strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         audio_out <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         x         <= '0;
         x_prev    <= '0;
         y_dcb     <= '0;
         l_acc     <= '0;
         d         <= '0;
         f         <= '0;
      end else begin
         out_valid <= 1'b0;
         if (ce_sample && (state != IDLE)) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (ce_sample) begin
                  x     <= ACC_W'(audio_in);
                  state <= CAPT;
               end
            end
            CAPT: state <= DCB;
            DCB: begin
               if (dcb_en) begin
                  y_dcb  <= dcb_y_c;
                  x_prev <= x;
                  d      <= dcb_y_c;
               end else begin
                  d <= x;
               end
               state <= LPF;
            end
            LPF: begin
               // When bypassed, track d so re-enabling starts without a step.
               if (lpf_en && (lpf_shift != 3'd0)) begin
                  l_acc <= lpf_l_c;
                  f     <= lpf_l_c;
               end else begin
                  l_acc <= d;
                  f     <= d;
               end
               state <= VOL;
            end
            VOL: begin
               audio_out <= sat_c;
               out_valid <= 1'b1;
               state     <= SAT;
            end
            SAT:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msx_audio_post.sv
// Directed self-checking bench for msx_audio_post.
module tb_msx_audio_post;
   import msx_audio_pkg::*;

   logic        clk;
   logic        reset;
   logic        ce_sample;
   logic [15:0] audio_in;
   logic        dcb_en;
   logic        lpf_en;
   logic [2:0]  lpf_shift;
   logic [3:0]  volume;
   logic [15:0] audio_out;
   logic        out_valid;
   logic        overrun;

   int errors = 0;
   int checks = 0;

   msx_audio_post dut (
      .clk       (clk),
      .reset     (reset),
      .ce_sample (ce_sample),
      .audio_in  (audio_in),
      .dcb_en    (dcb_en),
      .lpf_en    (lpf_en),
      .lpf_shift (lpf_shift),
      .volume    (volume),
      .audio_out (audio_out),
      .out_valid (out_valid),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Strobe one sample, wait for out_valid (lat counts edges from the strobe
   // edge), then step to IDLE. hit_sat raises a second strobe during SAT.
   task automatic run_sample(input logic [15:0] s, input bit hit_sat,
                             output logic [15:0] res, output int lat);
      @(posedge clk);
      #1 audio_in = s;
      ce_sample = 1'b1;
      @(posedge clk);
      #1 ce_sample = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!out_valid) check("timeout", 32'(lat), 32'd5);
      res = audio_out;
      if (hit_sat) begin
         audio_in  = 16'h0007;
         ce_sample = 1'b1;
      end
      @(posedge clk);
      #1 ce_sample = 1'b0;
   endtask

   task automatic count_pulses(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1 if (out_valid) n++;
      end
   endtask

   initial begin
      logic [15:0] res;
      logic [15:0] prev;
      int          lat;
      int          n;
      bit          mono;

      reset     = 1'b1;
      ce_sample = 1'b0;
      audio_in  = '0;
      dcb_en    = 1'b0;
      lpf_en    = 1'b0;
      lpf_shift = 3'd0;
      volume    = VOL_UNITY;
      #1;
      check("rst_out", 32'(audio_out), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      do_reset();

      // Pass-through with latency and pulse width.
      run_sample(16'h1234, 1'b0, res, lat);
      check("pt_latency", 32'(lat), 32'd5);
      check("pt_value", 32'(res), 32'h1234);
      check("pt_pulse_width", 32'(out_valid), 32'h0);

      // Saturation: 0x7000*15/8 and 0x9000*15/8 exceed 16 bits.
      volume = 4'd15;
      run_sample(16'h7000, 1'b0, res, lat);
      check("sat_pos", 32'(res), 32'h7fff);
      run_sample(16'h9000, 1'b0, res, lat);
      check("sat_neg", 32'(res), 32'h8000);
      volume = 4'd0;
      run_sample(16'h1234, 1'b0, res, lat);
      check("mute", 32'(res), 32'h0);
      volume = 4'd12;
      run_sample(16'h0100, 1'b0, res, lat);
      check("gain_1p5", 32'(res), 32'h0180);

      // DC blocker on a constant 1000: 1000, 997, ... The floor shift gives
      // y>>>8 = 0 below 256, so the decay stalls exactly at 255.
      volume = VOL_UNITY;
      dcb_en = 1'b1;
      run_sample(16'd1000, 1'b0, res, lat);
      check("dcb_first", 32'(res), 32'd1000);
      run_sample(16'd1000, 1'b0, res, lat);
      check("dcb_second", 32'(res), 32'd997);
      prev = res;
      mono = 1'b1;
      for (int i = 0; i < 600; i++) begin
         run_sample(16'd1000, 1'b0, res, lat);
         if (res > prev) mono = 1'b0;
         prev = res;
      end
      check("dcb_monotonic", 32'(mono), 32'h1);
      check("dcb_final", 32'(res), 32'd255);
      dcb_en = 1'b0;

      // Low-pass step response with k = 1.
      do_reset();
      lpf_en    = 1'b1;
      lpf_shift = 3'd1;
      run_sample(16'd0, 1'b0, res, lat);
      check("lpf_zero", 32'(res), 32'd0);
      run_sample(16'd1024, 1'b0, res, lat);
      check("lpf_step1", 32'(res), 32'd512);
      run_sample(16'd1024, 1'b0, res, lat);
      check("lpf_step2", 32'(res), 32'd768);
      run_sample(16'd1024, 1'b0, res, lat);
      check("lpf_step3", 32'(res), 32'd896);
      run_sample(16'd1024, 1'b0, res, lat);
      check("lpf_step4", 32'(res), 32'd960);

      // Overrun: second strobe 2 clk after the first is dropped.
      @(posedge clk);
      #1 audio_in = 16'd1024;
      ce_sample = 1'b1;
      @(posedge clk);
      #1 ce_sample = 1'b0;
      @(posedge clk);
      #1 audio_in = 16'd0;
      ce_sample = 1'b1;
      @(posedge clk);
      #1 ce_sample = 1'b0;
      n = 0;
      repeat (12) begin
         if (out_valid) begin
            n++;
            res = audio_out;
         end
         @(posedge clk);
         #1;
      end
      check("ovr_pulses", 32'(n), 32'd1);
      check("ovr_inflight", 32'(res), 32'd992);
      check("ovr_flag", 32'(overrun), 32'h1);
      run_sample(16'd1024, 1'b0, res, lat);
      check("ovr_next", 32'(res), 32'd1008);
      check("ovr_sticky", 32'(overrun), 32'h1);

      // Async reset while in DCB with l_acc = 1008.
      @(posedge clk);
      #1 audio_in = 16'd500;
      ce_sample = 1'b1;
      @(posedge clk);
      #1 ce_sample = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_out", 32'(audio_out), 32'h0);
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      check("mid_rst_overrun", 32'(overrun), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      count_pulses(10, n);
      check("mid_rst_no_pulse", 32'(n), 32'd0);
      run_sample(16'd1024, 1'b0, res, lat);
      check("post_rst_lpf", 32'(res), 32'd512);

      // Strobe landing on the SAT cycle is dropped.
      run_sample(16'd100, 1'b1, res, lat);
      check("sat_cycle_value", 32'(res), 32'd306);
      count_pulses(10, n);
      check("sat_cycle_dropped", 32'(n), 32'd0);
      check("sat_cycle_overrun", 32'(overrun), 32'h1);
      check("sat_cycle_hold", 32'(audio_out), 32'd306);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
